// File: rtl/mm2s_packet_router.sv
// MM2S receive-side router: splits one AXI Stream into per-channel FIFO write ports by tdest.
// Packets are routed whole; out-of-range destinations are drained and counted.
module mm2s_packet_router #(
    parameter int AXIS_DATA_WIDTH = 32,
    parameter int FIFO_DATA_WIDTH = 32,
    parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8,
    parameter int AXIS_DEST_WIDTH = 4,
    parameter int NUM_CHANNELS    = 2,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    input  logic                       SRC_AXIS_tvalid_in,
    output logic                       SRC_AXIS_tready_out,
    input  logic [AXIS_DATA_WIDTH-1:0] SRC_AXIS_tdata_in,
    input  logic [AXIS_DEST_WIDTH-1:0] SRC_AXIS_tdest_in,
    input  logic [AXIS_KEEP_WIDTH-1:0] SRC_AXIS_tkeep_in,
    input  logic                       SRC_AXIS_tlast_in,
    input  logic                       SRC_AXIS_tuser_in,
    output logic [FIFO_DATA_WIDTH-1:0] fifo_data_out,
    output logic                       fifo_last_out,
    output logic [NUM_CHANNELS-1:0]    fifo_w_stb_out,
    input  logic [NUM_CHANNELS-1:0]    fifo_full_in,
    output logic [CNT_WIDTH-1:0]       drop_count_out,
    output logic                       err_keep_out,
    output logic [1:0]                 state_dbg_out
);

    // Handshake: a beat transfers on a rising clk_in edge where tvalid & tready are both high;
    // tready is combinational from state, tdest (IDLE only) and the selected FIFO's full flag.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUTE = 2'd1,
        DROP  = 2'd2
    } state_t;

    localparam int MIN_W = (FIFO_DATA_WIDTH < AXIS_DATA_WIDTH) ? FIFO_DATA_WIDTH : AXIS_DATA_WIDTH;

    state_t                       state_q, state_d;
    logic [AXIS_DEST_WIDTH-1:0]   dest_q, dest_d;
    logic [AXIS_DEST_WIDTH-1:0]   route_dest;
    logic                         route_beat;
    logic                         drop_inc;
    logic                         accept;
    logic                         tready;
    logic                         dest_ok;
    logic [NUM_CHANNELS-1:0]      stb_d;
    logic [FIFO_DATA_WIDTH-1:0]   data_fit;
    logic                         unused_ok;

    assign unused_ok = SRC_AXIS_tuser_in;

    function automatic logic full_at(input logic [AXIS_DEST_WIDTH-1:0] d,
                                     input logic [NUM_CHANNELS-1:0] f);
        logic r;
        r = 1'b0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            if (d == AXIS_DEST_WIDTH'(c)) r = f[c];
        end
        return r;
    endfunction

    assign dest_ok = ({1'b0, SRC_AXIS_tdest_in} < (AXIS_DEST_WIDTH + 1)'(NUM_CHANNELS));

    always_comb begin
        state_d    = state_q;
        dest_d     = dest_q;
        tready     = 1'b0;
        route_beat = 1'b0;
        route_dest = dest_q;
        drop_inc   = 1'b0;
        accept     = 1'b0;
        case (state_q)
            IDLE: begin
                tready = dest_ok ? ~full_at(SRC_AXIS_tdest_in, fifo_full_in) : 1'b1;
                tready = tready & ~rst_in;
                accept = SRC_AXIS_tvalid_in & tready;
                if (accept) begin
                    if (dest_ok) begin
                        route_beat = 1'b1;
                        route_dest = SRC_AXIS_tdest_in;
                        if (!SRC_AXIS_tlast_in) begin
                            state_d = ROUTE;
                            dest_d  = SRC_AXIS_tdest_in;
                        end
                    end else if (SRC_AXIS_tlast_in) begin
                        drop_inc = 1'b1;
                    end else begin
                        state_d = DROP;
                    end
                end
            end
            ROUTE: begin
                tready = ~full_at(dest_q, fifo_full_in) & ~rst_in;
                accept = SRC_AXIS_tvalid_in & tready;
                if (accept) begin
                    route_beat = 1'b1;
                    if (SRC_AXIS_tlast_in) state_d = IDLE;
                end
            end
            DROP: begin
                tready = ~rst_in;
                accept = SRC_AXIS_tvalid_in & tready;
                if (accept && SRC_AXIS_tlast_in) begin
                    drop_inc = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        stb_d = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            stb_d[c] = route_beat && (route_dest == AXIS_DEST_WIDTH'(c));
        end
    end

    always_comb begin
        data_fit = '0;
        data_fit[MIN_W-1:0] = SRC_AXIS_tdata_in[MIN_W-1:0];
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q        <= IDLE;
            dest_q         <= '0;
            fifo_w_stb_out <= '0;
            fifo_data_out  <= '0;
            fifo_last_out  <= 1'b0;
            drop_count_out <= '0;
            err_keep_out   <= 1'b0;
        end else begin
            state_q        <= state_d;
            dest_q         <= dest_d;
            fifo_w_stb_out <= stb_d;
            if (route_beat) begin
                fifo_data_out <= data_fit;
                fifo_last_out <= SRC_AXIS_tlast_in;
            end
            // Saturate rather than wrap so a long run of bad packets never reads as few.
            if (drop_inc && (drop_count_out != {CNT_WIDTH{1'b1}})) begin
                drop_count_out <= drop_count_out + 1'b1;
            end
            if (accept && (SRC_AXIS_tkeep_in != {AXIS_KEEP_WIDTH{1'b1}})) begin
                err_keep_out <= 1'b1;
            end
        end
    end

    assign SRC_AXIS_tready_out = tready;
    assign state_dbg_out       = state_q;

endmodule
